// File: rtl/aleste_bus_pkg.sv
// Shared bus definitions for the Z80 Wishbone slaves: bus tags, mapper FSM states,
// default mapper I/O port and the SRAM strobe bundle with its per-state encoding.
package aleste_bus_pkg;

  localparam logic [1:0] TAG_MEM          = 2'b00;
  localparam logic [1:0] TAG_IO           = 2'b01;
  localparam logic [7:0] MAPPER_PORT_BASE = 8'hFC;
  localparam int         PAGE_SHIFT       = 14;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } mapper_state_e;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic dq_oe;
  } sram_ctl_t;

  localparam sram_ctl_t SRAM_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};

  // Strobes to present while in a given state; wr selects the write flavour.
  function automatic sram_ctl_t sram_ctl_for(input mapper_state_e st, input logic wr);
    sram_ctl_t c;
    c = SRAM_IDLE;
    case (st)
      SETUP: begin
        c.ce_n  = 1'b0;
        c.oe_n  = wr;
        c.dq_oe = wr;
      end
      ACCESS: begin
        c.ce_n  = 1'b0;
        c.oe_n  = wr;
        c.we_n  = ~wr;
        c.dq_oe = wr;
      end
      DONE:    c.dq_oe = wr;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/wb_mapper_sram_if.sv
// Wishbone link between the Z80 bus master and the SRAM mapper slave.
// dat_w carries master write data, dat_r carries slave read data.
interface wb_mapper_sram_if;
  logic [15:0] adr;
  logic [1:0]  tga;
  logic [7:0]  dat_w;
  logic [7:0]  dat_r;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;

  modport master (output adr, tga, dat_w, cyc, stb, we, input dat_r, ack);
  modport slave  (input adr, tga, dat_w, cyc, stb, we, output dat_r, ack);
endinterface

// File: rtl/wb_mapper_regs.sv
// Four 16 KB page registers behind I/O ports PORT_BASE..PORT_BASE+3 and the physical address
// composer. Define MAPPER_READBACK_EN to make the page registers readable over I/O.
module wb_mapper_regs
  import aleste_bus_pkg::*;
#(
  parameter int         PADDR_W   = 22,
  parameter logic [7:0] PORT_BASE = MAPPER_PORT_BASE
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic               wr_en,
  input  logic [7:0]         port,
  input  logic [7:0]         wr_data,
  input  logic [15:0]        mem_adr,
  output logic               port_hit,
  output logic [7:0]         rd_data,
  output logic [PADDR_W-1:0] phys_addr
);

  localparam int PG_W = PADDR_W - PAGE_SHIFT;

  logic [PG_W-1:0] page_q [4];
  logic [7:0]      port_off;

  // Offset decode keeps the four-port window correct even for a non-aligned base.
  assign port_off = port - PORT_BASE;
  assign port_hit = (port_off[7:2] == 6'd0);

  // NOTE: the page file is tiny and must come up as an identity map, so it is reset like
  // ordinary flops; larger storage arrays would normally be left unreset.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      for (int i = 0; i < 4; i++) page_q[i] <= PG_W'(i);
    end else if (wr_en && port_hit) begin
      page_q[port_off[1:0]] <= PG_W'(wr_data);
    end
  end

  assign phys_addr = {page_q[mem_adr[15:14]], mem_adr[13:0]};

`ifdef MAPPER_READBACK_EN
  // Page bits above PG_W read back as ones so an 8-bit view stays unambiguous.
  localparam logic [7:0] FILL = 8'hFF << PG_W;
  logic [7:0] page8;
  assign page8   = 8'(page_q[port_off[1:0]]);
  assign rd_data = port_hit ? (page8 | FILL) : 8'hFF;
`else
  assign rd_data = 8'hFF;
`endif

endmodule

// File: rtl/wb_mapper_sram.sv
// Z80 Wishbone slave mapping 16-bit addresses into paged SRAM with WAIT_STATES access cycles.
// Optional MAPPER_READBACK_EN makes the page registers readable (see wb_mapper_regs).
module wb_mapper_sram #(
  parameter int         WAIT_STATES      = 2,
  parameter int         PADDR_W          = 22,
  parameter logic [7:0] MAPPER_PORT_BASE = aleste_bus_pkg::MAPPER_PORT_BASE
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  wb_mapper_sram_if.slave    wbs,
  output logic [PADDR_W-1:0] sram_addr_o,
  input  logic [7:0]         sram_dq_i,
  output logic [7:0]         sram_dq_o,
  output logic               sram_dq_oe_o,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o
);
  import aleste_bus_pkg::*;

  mapper_state_e      state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               mem_wr_q, mem_wr_d;
  logic               ack_q, ack_d;
  logic [7:0]         dat_q, dat_d;
  sram_ctl_t          ctl_q, ctl_d;
  logic [PADDR_W-1:0] addr_q, addr_d;
  logic [7:0]         dq_q, dq_d;

  logic               req, is_io, io_wr, ctl_wr;
  logic               port_hit;
  logic [7:0]         rb_data;
  logic [PADDR_W-1:0] phys_addr;

  assign req   = wbs.cyc & wbs.stb;
  assign is_io = (wbs.tga == TAG_IO);

  wb_mapper_regs #(
    .PADDR_W   (PADDR_W),
    .PORT_BASE (MAPPER_PORT_BASE)
  ) u_regs (
    .clk_i     (clk_i),
    .nrst_i    (nrst_i),
    .wr_en     (io_wr),
    .port      (wbs.adr[7:0]),
    .wr_data   (wbs.dat_w),
    .mem_adr   (wbs.adr),
    .port_hit  (port_hit),
    .rd_data   (rb_data),
    .phys_addr (phys_addr)
  );

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_wr_d = mem_wr_q;
    ack_d    = 1'b0;
    dat_d    = dat_q;
    addr_d   = addr_q;
    dq_d     = dq_q;
    io_wr    = 1'b0;

    case (state_q)
      IDLE: if (req) begin
        mem_wr_d = wbs.we & ~is_io;
        if (is_io) begin
          state_d = DONE;
          io_wr   = wbs.we;
          if (!wbs.we) dat_d = rb_data;
        end else begin
          state_d = SETUP;
          addr_d  = phys_addr;
          dq_d    = wbs.dat_w;
        end
      end
      SETUP: begin
        if (!req) state_d = IDLE;
        else begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES - 1);
        end
      end
      ACCESS: begin
        if (!req) state_d = IDLE;
        else if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!mem_wr_q) dat_d = sram_dq_i;
        end else cnt_d = cnt_q - 4'd1;
      end
      DONE: begin
        // Ack is held for as long as the master keeps the strobe up; no re-trigger from here.
        if (req) ack_d = 1'b1;
        else     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered alongside the state so they line up with it cycle for cycle.
    ctl_wr = (state_q == IDLE) ? (wbs.we & ~is_io) : mem_wr_q;
    ctl_d  = sram_ctl_for(state_d, ctl_wr);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      mem_wr_q <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= 8'h00;
      ctl_q    <= SRAM_IDLE;
      addr_q   <= '0;
      dq_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_wr_q <= mem_wr_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      ctl_q    <= ctl_d;
      addr_q   <= addr_d;
      dq_q     <= dq_d;
    end
  end

  assign wbs.ack      = ack_q;
  assign wbs.dat_r    = dat_q;
  assign sram_addr_o  = addr_q;
  assign sram_dq_o    = dq_q;
  assign sram_dq_oe_o = ctl_q.dq_oe;
  assign sram_ce_n_o  = ctl_q.ce_n;
  assign sram_oe_n_o  = ctl_q.oe_n;
  assign sram_we_n_o  = ctl_q.we_n;

endmodule

// File: tb/tb_wb_mapper_sram.sv
// Bench for wb_mapper_sram: transaction table with a scoreboard queue, an async SRAM model,
// and hand-written sequences for ack hold, abort and mid-access reset.
module tb_wb_mapper_sram;
  import aleste_bus_pkg::*;

  localparam int W       = 2;
  localparam int PADDR_W = 22;

`ifdef MAPPER_READBACK_EN
  localparam logic [7:0] RB_FD = 8'h07;
  localparam logic [7:0] RB_FF = 8'h03;
`else
  localparam logic [7:0] RB_FD = 8'hFF;
  localparam logic [7:0] RB_FF = 8'hFF;
`endif

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  wb_mapper_sram_if bus ();

  logic [PADDR_W-1:0] sram_addr;
  logic [7:0]         sram_dq_i = 8'hEE;
  logic [7:0]         sram_dq_o;
  logic               sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  wb_mapper_sram #(.WAIT_STATES(W), .PADDR_W(PADDR_W), .MAPPER_PORT_BASE(8'hFC)) dut (
    .clk_i        (clk),
    .nrst_i       (nrst),
    .wbs          (bus),
    .sram_addr_o  (sram_addr),
    .sram_dq_i    (sram_dq_i),
    .sram_dq_o    (sram_dq_o),
    .sram_dq_oe_o (sram_dq_oe),
    .sram_ce_n_o  (sram_ce_n),
    .sram_oe_n_o  (sram_oe_n),
    .sram_we_n_o  (sram_we_n)
  );

  // SRAM model: unwritten locations read back addr[7:0]^8'h5A.
  logic [7:0] mem [logic [PADDR_W-1:0]];
  int n_access = 0;
  int n_we_low = 0;
  logic ce_prev = 1'b1;

  function automatic logic [7:0] sram_peek(input logic [PADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] = sram_dq_o;
    if (!sram_we_n) n_we_low++;
    if (ce_prev && !sram_ce_n) n_access++;
    ce_prev   = sram_ce_n;
    sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_peek(sram_addr) : 8'hEE;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int                 lat;
    logic               chk_addr;
    logic [PADDR_W-1:0] addr;
    logic               chk_dat;
    logic [7:0]         dat;
    logic               mem_wr;
    int                 n_acc;
    int                 we_low;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk_exp(input logic [1:0] tga, input logic we,
                                  input logic [PADDR_W-1:0] addr, input logic [7:0] dat);
    exp_t e;
    logic is_mem;
    is_mem     = (tga != TAG_IO);
    e.lat      = is_mem ? W + 2 : 1;
    e.chk_addr = is_mem;
    e.addr     = addr;
    e.chk_dat  = !we;
    e.dat      = dat;
    e.mem_wr   = is_mem && we;
    e.n_acc    = is_mem ? 1 : 0;
    e.we_low   = (is_mem && we) ? W : 0;
    return e;
  endfunction

  task automatic bus_idle();
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = 16'h0000; bus.tga = TAG_MEM; bus.dat_w = 8'h00;
  endtask

  task automatic run_txn(input logic [1:0] tga, input logic we, input logic [15:0] adr,
                         input logic [7:0] dat, input int hold, input string tag);
    int   lat, held, acc0, we0;
    logic dq_all, got;
    exp_t e;
    acc0 = n_access; we0 = n_we_low; got = 1'b0;
    @(negedge clk);
    bus.adr = adr; bus.tga = tga; bus.we = we; bus.dat_w = dat; bus.cyc = 1'b1; bus.stb = 1'b1;
    lat = -1; dq_all = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      dq_all &= sram_dq_oe;
    end while (!bus.ack && lat < 40);
    if (!bus.ack) begin
      n_checks++; n_errors++;
      $display("FAIL %s_ack_timeout: no ack after %0d edges", tag, lat);
    end else if (sb.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s_scoreboard: ack with no expected entry", tag);
    end else begin
      e = sb.pop_front();
      got = 1'b1;
      check({tag, "_lat"}, lat, e.lat);
      if (e.chk_addr) check({tag, "_addr"}, sram_addr, e.addr);
      if (e.chk_dat)  check({tag, "_dat"}, bus.dat_r, e.dat);
      if (e.mem_wr)   check({tag, "_dq_oe_held"}, dq_all, 1'b1);
    end
    held = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (bus.ack) held++;
    end
    if (hold > 0) check({tag, "_ack_hold"}, held, hold);
    @(negedge clk);
    bus_idle();
    @(posedge clk); #1;
    check({tag, "_ack_drop"}, bus.ack, 1'b0);
    @(negedge clk);
    if (got) begin
      check({tag, "_n_access"}, n_access - acc0, e.n_acc);
      check({tag, "_we_low"}, n_we_low - we0, e.we_low);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   bus.ack, 1'b0);
    check({tag, "_dat"},   bus.dat_r, 8'h00);
    check({tag, "_ce_n"},  sram_ce_n, 1'b1);
    check({tag, "_oe_n"},  sram_oe_n, 1'b1);
    check({tag, "_we_n"},  sram_we_n, 1'b1);
    check({tag, "_dq_oe"}, sram_dq_oe, 1'b0);
    check({tag, "_addr"},  sram_addr, 0);
    check({tag, "_dq_o"},  sram_dq_o, 8'h00);
  endtask

  typedef struct {
    logic [1:0]         tga;
    logic               we;
    logic [15:0]        adr;
    logic [7:0]         dat;
    logic [PADDR_W-1:0] exp_addr;
    logic [7:0]         exp_dat;
  } vec_t;

  vec_t vec [16];

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec[0]  = '{TAG_MEM, 1'b0, 16'hC005, 8'h00, 22'h00C005, 8'h5F};
    vec[1]  = '{TAG_IO,  1'b1, 16'h00FE, 8'h25, 22'h0,      8'h00};
    vec[2]  = '{TAG_MEM, 1'b0, 16'h8123, 8'h00, 22'h094123, 8'hA5};
    vec[3]  = '{TAG_MEM, 1'b1, 16'h4010, 8'h3C, 22'h004010, 8'h00};
    vec[4]  = '{TAG_MEM, 1'b0, 16'h4010, 8'h00, 22'h004010, 8'h3C};
    vec[5]  = '{TAG_IO,  1'b1, 16'h00FD, 8'h07, 22'h0,      8'h00};
    vec[6]  = '{TAG_IO,  1'b0, 16'h00FD, 8'h00, 22'h0,      RB_FD};
    vec[7]  = '{TAG_IO,  1'b0, 16'h0010, 8'h00, 22'h0,      8'hFF};
    vec[8]  = '{TAG_MEM, 1'b0, 16'h4010, 8'h00, 22'h01C010, 8'h4A};
    vec[9]  = '{TAG_IO,  1'b1, 16'h00FC, 8'hFF, 22'h0,      8'h00};
    vec[10] = '{TAG_MEM, 1'b0, 16'h3FFF, 8'h00, 22'h3FFFFF, 8'hA5};
    vec[11] = '{TAG_IO,  1'b1, 16'h0010, 8'hAA, 22'h0,      8'h00};
    vec[12] = '{TAG_IO,  1'b0, 16'h00FF, 8'h00, 22'h0,      RB_FF};
    vec[13] = '{TAG_MEM, 1'b0, 16'hC000, 8'h00, 22'h00C000, 8'h5A};
    vec[14] = '{2'b10,   1'b0, 16'h0001, 8'h00, 22'h3FC001, 8'h5B};
    vec[15] = '{2'b11,   1'b1, 16'h8002, 8'h99, 22'h094002, 8'h00};

    mem[22'h094123] = 8'hA5;
    bus_idle();
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      sb.push_back(mk_exp(vec[i].tga, vec[i].we, vec[i].exp_addr, vec[i].exp_dat));
      run_txn(vec[i].tga, vec[i].we, vec[i].adr, vec[i].dat, 0, $sformatf("vec%0d", i));
    end
    check("model_4010", sram_peek(22'h004010), 8'h3C);
    check("model_094002", sram_peek(22'h094002), 8'h99);

    // Strobe held 5 cycles past ack: ack stays up, only one SRAM access.
    sb.push_back(mk_exp(TAG_MEM, 1'b0, 22'h3FC002, 8'h58));
    run_txn(TAG_MEM, 1'b0, 16'h0002, 8'h00, 5, "hold");

    // Abort in ACCESS cycle 1, read then write.
    for (int wr = 0; wr < 2; wr++) begin
      int acks;
      @(negedge clk);
      bus.adr = 16'h0010; bus.tga = TAG_MEM; bus.we = wr[0]; bus.dat_w = 8'h66;
      bus.cyc = 1'b1; bus.stb = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      check($sformatf("abort%0d_in_access_ce_n", wr), sram_ce_n, 1'b0);
      check($sformatf("abort%0d_in_access_we_n", wr), sram_we_n, !wr[0]);
      @(negedge clk);
      bus_idle();
      @(posedge clk); #1;
      check($sformatf("abort%0d_ce_n", wr), sram_ce_n, 1'b1);
      check($sformatf("abort%0d_oe_n", wr), sram_oe_n, 1'b1);
      check($sformatf("abort%0d_we_n", wr), sram_we_n, 1'b1);
      check($sformatf("abort%0d_dq_oe", wr), sram_dq_oe, 1'b0);
      acks = 0;
      repeat (4) begin
        @(posedge clk); #1;
        if (bus.ack) acks++;
      end
      check($sformatf("abort%0d_no_ack", wr), acks, 0);
    end

    // Reset while a write is in ACCESS.
    @(negedge clk);
    bus.adr = 16'h8000; bus.tga = TAG_MEM; bus.we = 1'b1; bus.dat_w = 8'h11;
    bus.cyc = 1'b1; bus.stb = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("rst_mid_we_n_low", sram_we_n, 1'b0);
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    bus_idle();
    nrst = 1'b1;

    // Page registers are back to the identity map after reset.
    sb.push_back(mk_exp(TAG_MEM, 1'b0, 22'h008123, 8'h79));
    run_txn(TAG_MEM, 1'b0, 16'h8123, 8'h00, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
